fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of one synchronous FIFO (`DATA_WIDTH` wide, `full` status) among `NUM_REQ` producers. Each grant lets one producer write a burst of up to `MAX_BURST` words. Writes are stalled while the FIFO reports `full`. The block sits between the producer agents and the FIFO's `Wr_enable`/`data_in` pins. The FIFO's read side is untouched.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of producers (2..16).
- `DATA_WIDTH`, default 32: FIFO word width.
- `MAX_BURST`, default 4: maximum words per grant (≥1).

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in `NUM_REQ`: producer i holds a valid word; it must keep `req[i]` and its data stable until `ack[i]`.
- `req_data` in `NUM_REQ*DATA_WIDTH`: packed words; producer i uses `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_last` in `NUM_REQ`: the presented word is the producer's final word of this burst.
- `ack` out `NUM_REQ`: one-hot; the word from producer i is written this cycle.
- `Wr_enable` out 1: FIFO write strobe.
- `data_in` out `DATA_WIDTH`: FIFO write data.
- `full` in 1: FIFO full status.
- `grant_valid` out 1: a producer currently holds the grant.
- `grant_id` out `$clog2(NUM_REQ)`: index of the granted producer; 0 when `grant_valid`=0.

## Operation
- Two states, IDLE and GRANT. Registers:
  - `state`
  - `grant_id`
  - `last_grant`
  - `burst_cnt` (width `$clog2(MAX_BURST+1)`)
- Reset: state=IDLE, `grant_id`=0, `burst_cnt`=0, `last_grant`=`NUM_REQ-1`, so producer 0 has first priority.
- IDLE, with any `req` bit set:
  - Choose the first set bit searching upward from `last_grant+1`, wrapping modulo `NUM_REQ`.
  - Next state is GRANT, `grant_id` = winner, `burst_cnt`=0.
  - No write happens in an IDLE cycle.
- GRANT, with g=`grant_id`:
  - write = `req[g]` & !`full` & !`reset`.
  - On write: `Wr_enable`=1, `data_in`=`req_data[g]`, `ack[g]`=1, `burst_cnt`+1.
- Release from GRANT back to IDLE with `last_grant`=g, when any of these holds:
  - (a) a write occurs with `req_last[g]`=1;
  - (b) a write occurs with `burst_cnt`==`MAX_BURST-1`;
  - (c) `req[g]`=0 (producer withdrew; no write).
- `full`=1 in GRANT: stall. No write, `burst_cnt` held, grant held indefinitely (no timeout). If `req[g]` drops while stalled, rule (c) applies.
- Requests from other producers never pre-empt an active grant.
- Outputs when not writing:
  - `Wr_enable`=0;
  - `ack`=0;
  - `data_in`=`req_data[grant_id]` in GRANT, all-zero in IDLE.
- At most one write per cycle. `ack` is never asserted for a non-granted producer.

## Timing
- `Wr_enable`, `data_in` and `ack` are combinational from the state registers, `req`, `req_data` and `full`. The FIFO samples them on the same edge at which the grant logic advances. Write latency is zero from `req` inside GRANT.
- The first write of a grant occurs one cycle after the IDLE arbitration cycle. There is exactly one bubble cycle between consecutive bursts.
- `full` is sampled in the same cycle it gates `Wr_enable`, so there is no overrun.
- Throughput under continuous requests: `MAX_BURST` words every `MAX_BURST+1` cycles.
- `reset` asserted mid-burst: `Wr_enable`/`ack` are forced to 0 in that cycle. The following cycle is IDLE with all registers at their reset values.
- Reset values of outputs: `Wr_enable`=0, `ack`=0, `data_in`=0, `grant_valid`=0, `grant_id`=0.

## Test plan
Parameters are `NUM_REQ`=4 and `MAX_BURST`=4 unless stated otherwise.
- **Reset:** hold `reset` 2 cycles with `req`=4'b1111.
  - Required: `Wr_enable`=0, `ack`=0, `grant_valid`=0 throughout.
  - Required: the first grant after release goes to producer 0.
- **Single producer:** `req[2]` with words 0xA, 0xB, 0xC, `req_last` on 0xC.
  - Required: one IDLE cycle, then 3 consecutive writes 0xA/0xB/0xC with `ack`=4'b0100.
  - Required: back to IDLE, `last_grant`=2.
- **All producers saturated:** `req`=4'b1111 continuously, `req_last`=0.
  - Required: grant order 0,1,2,3,0.
  - Required: each grant writes exactly 4 words, with one bubble between grants (16 words in 20 cycles).
- **Full stall:** `full`=1 for 3 cycles after the 2nd word of producer 1's burst.
  - Required: no `Wr_enable`/`ack` during the stall and `burst_cnt` held at 2.
  - Required: words 3 and 4 are written after the stall, then release.
- **Wrap priority:** `last_grant`=1, `req`=4'b1010.
  - Required: producer 3 wins.
  - Required: after producer 3 releases, producer 1 wins.
- **Withdrawal and mid-burst reset:**
  - Producer 0 drops `req` after 1 word. Required: release with no write in that cycle.
  - Assert `reset` during producer 2's 2nd word. Required: `Wr_enable`=0 in the reset cycle and the next grant goes to producer 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// granting bursts of up to MAX_BURST words and stalling on full.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          Wr_enable,
    output logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          full,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_n;
    logic [IW-1:0] last_grant, last_grant_n, grant_id_n, winner, cand;
    logic [BW-1:0] burst_cnt, burst_cnt_n;
    logic          write, rel;

    // Scan from farthest to nearest so the first requester after last_grant wins
    always_comb begin
        winner = last_grant;
        cand   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IW'((int'(last_grant) + k) % NUM_REQ);
            if (req[cand]) winner = cand;
        end
    end

    assign write       = state == GRANT && req[grant_id] && !full && !reset;
    assign Wr_enable   = write;
    assign ack         = write ? NUM_REQ'(1) << grant_id : '0;
    assign data_in     = state == GRANT ? req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign grant_valid = state == GRANT;
    assign rel         = state == GRANT && (!req[grant_id] ||
                         (write && (req_last[grant_id] || burst_cnt == BW'(MAX_BURST - 1))));

    always_comb begin
        state_n      = state;
        grant_id_n   = grant_id;
        last_grant_n = last_grant;
        burst_cnt_n  = burst_cnt;
        if (write) burst_cnt_n = burst_cnt + BW'(1);
        if (rel) begin
            state_n      = IDLE;
            grant_id_n   = '0;
            last_grant_n = grant_id;
        end
        if (state == IDLE && |req) begin
            state_n     = GRANT;
            grant_id_n  = winner;
            burst_cnt_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            burst_cnt  <= '0;
        end else begin
            state      <= state_n;
            grant_id   <= grant_id_n;
            last_grant <= last_grant_n;
            burst_cnt  <= burst_cnt_n;
        end
    end
endmodule
